// File: rtl/enable_phase_sequencer.sv
// ---------------------------------------------------------------------------
// enable_phase_sequencer
//
// Takes the single-cycle enable pulse stream from the enable generator,
// optionally decimates it, and fans each accepted pulse out to N_OUTPUTS
// phase-delayed single-cycle enables at fixed offsets within the control
// period.
//
// On an accepted pulse at cycle t, enable_out[i] fires at cycle t+1+delay[i]
// if output i is unmasked. The delays and the mask are captured at the
// accepted pulse, so later input changes do not affect the running sequence.
// A pulse accepted while a sequence is still running restarts the sequence
// and raises overrun for one cycle.
//
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous active-low reset
//   gen_enable_in  block enable; low aborts any sequence and clears state
//   enable_in      single-cycle enable pulse from the enable generator
//   delays         packed delays; slice i is the delay of output i (cycles)
//   divider        accept every divider-th enable_in pulse; 0 acts as 1
//   output_mask    bit i = 1 enables output i
//   enable_out     single-cycle phase-delayed enables
//   sequence_busy  high while a sequence is pending
//   overrun        single-cycle pulse when a sequence restarts early
// ---------------------------------------------------------------------------
module enable_phase_sequencer #(
    parameter int unsigned N_OUTPUTS   = 4,
    parameter int unsigned DELAY_WIDTH = 16,
    parameter int unsigned DIV_WIDTH   = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             gen_enable_in,
    input  logic                             enable_in,
    input  logic [N_OUTPUTS*DELAY_WIDTH-1:0] delays,
    input  logic [DIV_WIDTH-1:0]             divider,
    input  logic [N_OUTPUTS-1:0]             output_mask,
    output logic [N_OUTPUTS-1:0]             enable_out,
    output logic                             sequence_busy,
    output logic                             overrun
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                           state_q, state_d;
    logic [DELAY_WIDTH:0]             cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0]             dec_cnt_q, dec_cnt_d;
    logic [N_OUTPUTS*DELAY_WIDTH-1:0] delays_q, delays_d;
    logic [N_OUTPUTS-1:0]             mask_q, mask_d;
    logic [DELAY_WIDTH-1:0]           max_q, max_d;
    logic                             overrun_q, overrun_d;

    logic                             accept;
    logic [DELAY_WIDTH-1:0]           max_in;
    logic [DIV_WIDTH:0]               div_eff;
    logic [DIV_WIDTH:0]               dec_next;

    // Largest delay among the outputs that are enabled; 0 when all are masked.
    always_comb begin
        max_in = '0;
        for (int i = 0; i < N_OUTPUTS; i++) begin
            if (output_mask[i] && (delays[i*DELAY_WIDTH +: DELAY_WIDTH] > max_in)) begin
                max_in = delays[i*DELAY_WIDTH +: DELAY_WIDTH];
            end
        end
    end

    // Divider of 0 behaves as 1. Extra bit keeps dec_next from overflowing.
    assign div_eff  = (divider == '0) ? (DIV_WIDTH+1)'(1) : {1'b0, divider};
    assign dec_next = {1'b0, dec_cnt_q} + (DIV_WIDTH+1)'(1);
    assign accept   = gen_enable_in && enable_in && (dec_cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dec_cnt_d = dec_cnt_q;
        delays_d  = delays_q;
        mask_d    = mask_q;
        max_d     = max_q;
        overrun_d = 1'b0;

        if (!gen_enable_in) begin
            state_d   = StIdle;
            cnt_d     = '0;
            dec_cnt_d = '0;
            delays_d  = '0;
            mask_d    = '0;
            max_d     = '0;
        end else begin
            if (enable_in) begin
                // >= also recovers cleanly if the divider shrinks mid-count.
                dec_cnt_d = (dec_next >= div_eff) ? '0 : dec_next[DIV_WIDTH-1:0];
            end

            if (accept) begin
                // Outputs matching this cycle already fire from the current
                // registers; everything later in the old sequence is dropped.
                overrun_d = (state_q == StRun);
                state_d   = StRun;
                cnt_d     = '0;
                delays_d  = delays;
                mask_d    = output_mask;
                max_d     = max_in;
            end else if (state_q == StRun) begin
                if (cnt_q == {1'b0, max_q}) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + (DELAY_WIDTH+1)'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            dec_cnt_q <= '0;
            delays_q  <= '0;
            mask_q    <= '0;
            max_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dec_cnt_q <= dec_cnt_d;
            delays_q  <= delays_d;
            mask_q    <= mask_d;
            max_q     <= max_d;
            overrun_q <= overrun_d;
        end
    end

    assign sequence_busy = (state_q == StRun);
    assign overrun       = overrun_q;

    always_comb begin
        enable_out = '0;
        for (int i = 0; i < N_OUTPUTS; i++) begin
            enable_out[i] = sequence_busy && mask_q[i] &&
                            (cnt_q == {1'b0, delays_q[i*DELAY_WIDTH +: DELAY_WIDTH]});
        end
    end

endmodule
